// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and the latched command.
// Widths here fix the command register layout used by mem_port_arbiter.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_I  = 2'd1,
        SERVE_D  = 2'd2,
        COOLDOWN = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  read;
        logic                  write;
        logic [ARB_BE_W-1:0]   byte_en;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_cmd_t;

    function automatic logic is_serving(arb_state_t s);
        return (s == SERVE_I) || (s == SERVE_D);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_cmd_reg.sv
// Command register: captures the winning requester's command at grant and holds it
// for the whole downstream transaction.
module mem_port_arbiter_cmd_reg
    import mem_port_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_load,
    input  arb_cmd_t i_cmd,
    output arb_cmd_t o_cmd
);

    arb_cmd_t r_cmd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd <= '0;
        end else if (i_load) begin
            r_cmd <= i_cmd;
        end
    end

    assign o_cmd = r_cmd;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and data access.
// Optional ARB_ROUND_ROBIN_EN: last-winner fairness instead of fixed data priority.
//
// state    | meaning
// IDLE     | arbitrate; latch the winner's command on grant
// SERVE_I  | fetch command on the port, waiting for mem_resp
// SERVE_D  | data command on the port, waiting for mem_resp
// COOLDOWN | one quiet cycle so the served requester can drop its request
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ARB_ADDR_W,
    parameter int DATA_WIDTH = ARB_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   imem_address,
    input  logic                    imem_read,
    output logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic                    imem_resp,
    input  logic [ADDR_WIDTH-1:0]   dmem_address,
    input  logic                    dmem_read,
    input  logic                    dmem_write,
    input  logic [DATA_WIDTH/8-1:0] dmem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    dmem_resp,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp,
    output logic                    grant_d
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    arb_cmd_t   w_cmd_nxt;
    arb_cmd_t   w_cmd;
    logic       w_d_req;
    logic       w_pick_d;
    logic       w_load;
    logic       w_serving;

    assign w_d_req = dmem_read | dmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // Cleared to the instruction side, so the first contested grant goes to data.
    logic r_last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_load) begin
            r_last_d <= w_pick_d;
        end
    end

    assign w_pick_d = w_d_req & (~imem_read | ~r_last_d);
`else
    assign w_pick_d = w_d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_d_req) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_pick_d ? SERVE_D : SERVE_I;
                end else if (imem_read) begin
                    w_load      = 1'b1;
                    w_state_nxt = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    w_state_nxt = COOLDOWN;
                end
            end
            COOLDOWN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A simultaneous read+write from the data port is resolved as a write.
    always_comb begin
        w_cmd_nxt = '0;
        if (w_pick_d) begin
            w_cmd_nxt.addr    = dmem_address;
            w_cmd_nxt.read    = dmem_read & ~dmem_write;
            w_cmd_nxt.write   = dmem_write;
            w_cmd_nxt.byte_en = dmem_byte_enable;
            w_cmd_nxt.wdata   = dmem_wdata;
        end else begin
            w_cmd_nxt.addr    = imem_address;
            w_cmd_nxt.read    = 1'b1;
            w_cmd_nxt.byte_en = '1;
        end
    end

    mem_port_arbiter_cmd_reg u_cmd_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_cmd  (w_cmd_nxt),
        .o_cmd  (w_cmd)
    );

    assign w_serving       = is_serving(r_state);
    assign mem_address     = w_cmd.addr;
    assign mem_read        = w_serving & w_cmd.read;
    assign mem_write       = w_serving & w_cmd.write;
    assign mem_byte_enable = w_cmd.byte_en;
    assign mem_wdata       = w_cmd.wdata;

    assign grant_d    = (r_state == SERVE_D);
    assign imem_resp  = (r_state == SERVE_I) & mem_resp;
    assign dmem_resp  = (r_state == SERVE_D) & mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : '0;
    assign dmem_rdata = dmem_resp ? mem_rdata : '0;

`ifndef SYNTHESIS
    a_no_read_and_write: assert property (@(posedge clk) disable iff (rst)
        (r_state == IDLE && w_load && w_pick_d) |-> !(dmem_read && dmem_write))
        else $error("dmem_read and dmem_write both asserted at grant");
`endif

endmodule
